ise_ctrl: RTL
=============

ISE_CTRL -- requirements
Module: ise_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_NUM, default 32, number of images per batch.
REQ-002 SHALL have parameter IMAGE_SIZE, default 128, image edge in pixels; PIX_PER_IMG = IMAGE_SIZE*IMAGE_SIZE (16384).
REQ-003 SHALL have ports:
  clk  input  1  single clock, all logic on rising edge
  reset  input  1  asynchronous, active-low
  in_valid  input  1  pixel present this cycle
  image_in_index  input  5  index of image owning current pixel
  busy  output  1  pixel not accepted this cycle
  acc_en  output  1  datapath accumulates pixel_in this cycle
  acc_first  output  1  pixel is first of its image (datapath loads, not adds)
  commit  output  1  datapath stores finished image result
  commit_slot  output  5  result-memory slot for commit
  commit_index  output  5  image index latched at first pixel
  sort_start  output  1  one-cycle pulse starting sorter
  sort_done  input  1  sorter finished
  rd_en  output  1  read sorted result memory
  rd_addr  output  5  sorted position being read
  rd_color  input  2  color code returned cycle after rd_en
  rd_index  input  5  image index returned cycle after rd_en
  out_valid  output  1  result valid
  color_index  output  2  dominant color (0 R, 1 G, 2 B)
  image_out_index  output  5  image index
  idx_err  output  1  sticky: image_in_index changed mid-image

Function
REQ-004 SHALL implement FSM states IDLE, ACCUM, COMMIT, SORT, OUTPUT.
REQ-005 busy SHALL be decoded from state only: 1 in COMMIT, SORT, OUTPUT; 0 in IDLE, ACCUM.
REQ-006 Pixel SHALL be accepted when in_valid=1 and busy=0; acc_en = that condition, combinational.
REQ-007 acc_first SHALL equal acc_en and pix_cnt==0; on it image_in_index SHALL be latched as commit_index.
REQ-008 IDLE -> ACCUM on first accepted pixel; pix_cnt (14 bit) SHALL increment per accepted pixel.
REQ-009 Acceptance with pix_cnt==PIX_PER_IMG-1 SHALL wrap pix_cnt to 0 and enter COMMIT next cycle.
REQ-010 COMMIT lasts exactly one cycle: commit=1, commit_slot=img_cnt; img_cnt increments.
REQ-011 From COMMIT: img_cnt==IMAGE_NUM-1 -> SORT with sort_start=1 in first SORT cycle only; else -> ACCUM.
REQ-012 SORT SHALL hold until sort_done=1, then enter OUTPUT; sort_done outside SORT SHALL be ignored.
REQ-013 OUTPUT SHALL assert rd_en for IMAGE_NUM consecutive cycles, rd_addr 0..IMAGE_NUM-1.
REQ-014 out_valid, color_index, image_out_index SHALL be registered from rd_color/rd_index one cycle after each rd_en; 32 contiguous out_valid pulses.
REQ-015 After rd_addr==IMAGE_NUM-1 the FSM SHALL return to IDLE with img_cnt=0; busy falls the cycle the last out_valid is high.
REQ-016 In_valid=1 while busy=1 SHALL have no effect (pixel held by source).
REQ-017 idx_err SHALL set when an accepted non-first pixel has image_in_index != commit_index; cleared only by reset.
REQ-018 in_valid low mid-image SHALL stall counters without state change.

Reset
REQ-019 reset=0 SHALL asynchronously force IDLE, pix_cnt=0, img_cnt=0, rd_addr=0, idx_err=0, all outputs 0.
REQ-020 Reset mid-batch SHALL discard partial progress; next accepted pixel is acc_first of slot 0.

Structure
REQ-021 Shared package ise_pkg SHALL hold IMAGE_NUM, IMAGE_SIZE, PIX_PER_IMG, FSM state type, color codes.
REQ-022 Output sequencing (rd_addr counter plus output register stage) SHALL be sub-module ise_out_seq.

Verification
REQ-023 Single image, in_valid continuous: acc_first on pixel 0, commit=1 one cycle after 16384th acceptance, commit_slot=0, busy=1 that cycle only.
REQ-024 Full batch of 32x16384 pixels, continuous: exactly 32 commits, slots 0..31, one sort_start pulse.
REQ-025 sort_done delayed 100 cycles: busy=1 throughout, no rd_en; stray sort_done in ACCUM ignored.
REQ-026 Sorter memory returns index 31-k at address k: out_valid 32 contiguous cycles, image_out_index 31..0, starting cycle after first rd_en.
REQ-027 image_in_index changes at pixel 5000 of image 3: idx_err=1 and stays; commit_index for slot 3 unchanged.
REQ-028 reset asserted at pixel 8000 of image 10: outputs 0 immediately; restarted batch commits slot 0 first.

Source files
------------

// File: rtl/ise_pkg.sv
// Shared constants and types for the image-statistics engine controller.
// Holds batch geometry defaults, the controller state type and color codes.
package ise_pkg;

    localparam int IMAGE_NUM   = 32;
    localparam int IMAGE_SIZE  = 128;
    localparam int PIX_PER_IMG = IMAGE_SIZE * IMAGE_SIZE;
    localparam int PIX_W       = 14;
    localparam int IDX_W       = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_COMMIT = 3'd2,
        ST_SORT   = 3'd3,
        ST_OUTPUT = 3'd4
    } state_t;

    localparam logic [1:0] COLOR_R = 2'd0;
    localparam logic [1:0] COLOR_G = 2'd1;
    localparam logic [1:0] COLOR_B = 2'd2;

endpackage

// File: rtl/ise_out_seq.sv
// Result read-out sequencer: walks the sorted memory address 0..IMAGE_NUM-1
// while active and registers the returned color/index as the result stream.
module ise_out_seq #(
    parameter int IMAGE_NUM = ise_pkg::IMAGE_NUM
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       active,
    input  logic [1:0] rd_color,
    input  logic [4:0] rd_index,
    output logic       rd_en,
    output logic [4:0] rd_addr,
    output logic       rd_last,
    output logic       out_valid,
    output logic [1:0] color_index,
    output logic [4:0] image_out_index
);

    localparam logic [4:0] LAST_ADDR = 5'(IMAGE_NUM - 1);

    assign rd_en   = active;
    assign rd_last = active && (rd_addr == LAST_ADDR);

    // Memory data for the address presented this cycle is captured at the
    // closing edge, so each result appears the cycle after its rd_en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_addr         <= '0;
            out_valid       <= 1'b0;
            color_index     <= '0;
            image_out_index <= '0;
        end else begin
            if (rd_en) begin
                rd_addr <= rd_last ? '0 : rd_addr + 5'd1;
            end
            out_valid       <= rd_en;
            color_index     <= rd_en ? rd_color : 2'd0;
            image_out_index <= rd_en ? rd_index : 5'd0;
        end
    end

endmodule

// File: rtl/ise_ctrl.sv
// Batch controller: counts pixels per image, commits each image result,
// triggers the sorter after the last image and streams the sorted results.
module ise_ctrl
    import ise_pkg::*;
#(
    parameter int IMAGE_NUM  = ise_pkg::IMAGE_NUM,
    parameter int IMAGE_SIZE = ise_pkg::IMAGE_SIZE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [4:0] image_in_index,
    output logic       busy,
    output logic       acc_en,
    output logic       acc_first,
    output logic       commit,
    output logic [4:0] commit_slot,
    output logic [4:0] commit_index,
    output logic       sort_start,
    input  logic       sort_done,
    output logic       rd_en,
    output logic [4:0] rd_addr,
    input  logic [1:0] rd_color,
    input  logic [4:0] rd_index,
    output logic       out_valid,
    output logic [1:0] color_index,
    output logic [4:0] image_out_index,
    output logic       idx_err,
    output state_t     state_dbg
);

    localparam logic [13:0] PIX_LAST = 14'(IMAGE_SIZE * IMAGE_SIZE - 1);
    localparam logic [4:0]  IMG_LAST = 5'(IMAGE_NUM - 1);

    state_t      state_q, state_d;
    logic [13:0] pix_cnt;
    logic [4:0]  img_cnt;
    logic        sort_first;
    logic        seq_active;
    logic        rd_last;
    logic        last_pix;

    // Pixel handshake: a pixel transfers on a cycle with in_valid=1 and busy=0;
    // while busy=1 the source holds the pixel and in_valid has no effect.
    assign last_pix  = acc_en && (pix_cnt == PIX_LAST);
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pix_cnt      <= '0;
            img_cnt      <= '0;
            commit_index <= '0;
            idx_err      <= 1'b0;
            sort_first   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sort_first <= (state_d == ST_SORT) && (state_q != ST_SORT);
            if (acc_en) begin
                pix_cnt <= last_pix ? '0 : pix_cnt + 14'd1;
                if (acc_first) begin
                    commit_index <= image_in_index;
                end else if (image_in_index != commit_index) begin
                    idx_err <= 1'b1;
                end
            end
            if (state_q == ST_COMMIT) begin
                img_cnt <= (img_cnt == IMG_LAST) ? '0 : img_cnt + 5'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (acc_en) state_d = last_pix ? ST_COMMIT : ST_ACCUM;
            ST_ACCUM:  if (last_pix) state_d = ST_COMMIT;
            ST_COMMIT: state_d = (img_cnt == IMG_LAST) ? ST_SORT : ST_ACCUM;
            ST_SORT:   if (sort_done) state_d = ST_OUTPUT;
            ST_OUTPUT: if (rd_last) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        commit      = 1'b0;
        commit_slot = '0;
        sort_start  = 1'b0;
        seq_active  = 1'b0;
        case (state_q)
            ST_COMMIT: begin
                busy        = 1'b1;
                commit      = 1'b1;
                commit_slot = img_cnt;
            end
            ST_SORT: begin
                busy       = 1'b1;
                sort_start = sort_first;
            end
            ST_OUTPUT: begin
                busy       = 1'b1;
                seq_active = 1'b1;
            end
            default: ;
        endcase
        // Gated by reset so every output reads 0 while reset is held.
        acc_en    = in_valid && !busy && reset;
        acc_first = acc_en && (pix_cnt == '0);
    end

    ise_out_seq #(.IMAGE_NUM(IMAGE_NUM)) u_out_seq (
        .clk             (clk),
        .reset           (reset),
        .active          (seq_active),
        .rd_color        (rd_color),
        .rd_index        (rd_index),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_last         (rd_last),
        .out_valid       (out_valid),
        .color_index     (color_index),
        .image_out_index (image_out_index)
    );

endmodule
